// File: rtl/axi_w_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_w_arbiter_if
// Purpose  : Bundles the two requester ports, the write-master command/B
//            completion port and the status flags of axi_w_arbiter.
//            slave  = arbiter side, master = requesters / write-master side.
// Revision : 1.0  initial release
// ============================================================================
interface axi_w_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4,
  parameter int RESP_W = 2
);
  // requester 0 (dcache writeback)
  logic              s0_valid;
  logic              s0_ready;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic [LEN_W-1:0]  s0_len;
  logic [1:0]        s0_size;
  logic              s0_done;
  logic [RESP_W-1:0] s0_resp;
  // requester 1 (uncached / MMIO store)
  logic              s1_valid;
  logic              s1_ready;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [LEN_W-1:0]  s1_len;
  logic [1:0]        s1_size;
  logic              s1_done;
  logic [RESP_W-1:0] s1_resp;
  // write master command and completion
  logic              m_valid;
  logic              m_ready;
  logic [ID_W-1:0]   m_id;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [LEN_W-1:0]  m_len;
  logic [1:0]        m_size;
  logic              m_done;
  logic [RESP_W-1:0] m_resp;
  // status
  logic              busy;
  logic              err_spurious;

  modport slave (
    input  s0_valid, s0_addr, s0_data, s0_len, s0_size,
    output s0_ready, s0_done, s0_resp,
    input  s1_valid, s1_addr, s1_data, s1_len, s1_size,
    output s1_ready, s1_done, s1_resp,
    output m_valid, m_id, m_addr, m_data, m_len, m_size,
    input  m_ready, m_done, m_resp,
    output busy, err_spurious
  );

  modport master (
    output s0_valid, s0_addr, s0_data, s0_len, s0_size,
    input  s0_ready, s0_done, s0_resp,
    output s1_valid, s1_addr, s1_data, s1_len, s1_size,
    input  s1_ready, s1_done, s1_resp,
    input  m_valid, m_id, m_addr, m_data, m_len, m_size,
    output m_ready, m_done, m_resp,
    input  busy, err_spurious
  );
endinterface
`default_nettype wire

// File: rtl/axi_w_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_w_arbiter
// Purpose  : Round-robin arbiter between two write requesters in front of the
//            AXI write master. Latches the winning command for the whole
//            AW/W/B sequence and routes the completion back to its owner.
// Revision : 1.0  initial release
// ============================================================================
module axi_w_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4,
  parameter int RESP_W = 2
) (
  input  wire              clk,
  input  wire              reset_n,
  axi_w_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_size;
  logic              r_s0_done;
  logic              r_s1_done;
  logic [RESP_W-1:0] r_s0_resp;
  logic [RESP_W-1:0] r_s1_resp;
  logic              r_err;

  logic              w_accept;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [LEN_W-1:0]  w_len;
  logic [1:0]        w_size;

  // Pick the winner in IDLE: a lone requester wins, a tie goes to the one
  // that did not complete last, then mux its command fields.
  always_comb begin
    w_accept = (r_state == S_IDLE) && (bus.s0_valid || bus.s1_valid);
    w_sel    = (bus.s0_valid && bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
    w_addr   = w_sel ? bus.s1_addr : bus.s0_addr;
    w_data   = w_sel ? bus.s1_data : bus.s0_data;
    w_len    = w_sel ? bus.s1_len  : bus.s0_len;
    w_size   = w_sel ? bus.s1_size : bus.s0_size;
  end

  // Sequencing: accept/latch in IDLE, present in ISSUE, route B in WAIT.
  // A done outside WAIT (including the ISSUE handshake cycle) is flagged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_id         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_s0_done    <= 1'b0;
      r_s1_done    <= 1'b0;
      r_s0_resp    <= '0;
      r_s1_resp    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_s0_done <= 1'b0;
      r_s1_done <= 1'b0;
      if (bus.m_done && (r_state != S_WAIT)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant <= w_sel;
            r_id    <= ID_W'(w_sel);
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_len   <= w_len;
            r_size  <= w_size;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.m_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.m_done) begin
            if (r_grant) begin
              r_s1_done <= 1'b1;
              r_s1_resp <= bus.m_resp;
            end else begin
              r_s0_done <= 1'b1;
              r_s0_resp <= bus.m_resp;
            end
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s0_ready     = w_accept && !w_sel;
  assign bus.s1_ready     = w_accept &&  w_sel;
  assign bus.s0_done      = r_s0_done;
  assign bus.s1_done      = r_s1_done;
  assign bus.s0_resp      = r_s0_resp;
  assign bus.s1_resp      = r_s1_resp;
  assign bus.m_valid      = (r_state == S_ISSUE);
  assign bus.m_id         = r_id;
  assign bus.m_addr       = r_addr;
  assign bus.m_data       = r_data;
  assign bus.m_len        = r_len;
  assign bus.m_size       = r_size;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.err_spurious = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_w_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_w_arbiter
// Purpose  : Directed self-checking bench for axi_w_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_w_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  axi_w_arbiter_if bus ();

  axi_w_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to the next sampling point (falling edge)
  task automatic nc();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] l, input logic [1:0] sz);
    if (n == 0) begin
      bus.s0_valid = v; bus.s0_addr = a; bus.s0_data = d; bus.s0_len = l; bus.s0_size = sz;
    end else begin
      bus.s1_valid = v; bus.s1_addr = a; bus.s1_data = d; bus.s1_len = l; bus.s1_size = sz;
    end
  endtask

  task automatic do_reset();
    nc();
    reset_n = 1'b0;
    nc();
    reset_n = 1'b1;
  endtask

  // single-requester transaction with m_ready high; accept is cycle 0,
  // m_done pulses at cycle done_cyc, done expected the cycle after
  task automatic run_one(input int n, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] l, input logic [1:0] sz,
                         input logic [1:0] rsp, input int done_cyc);
    logic own_done;
    logic oth_done;
    nc();
    set_req(n, 1'b1, a, d, l, sz);
    #1;
    chk("ready_own", (n == 0) ? bus.s0_ready : bus.s1_ready, 1);
    chk("ready_oth", (n == 0) ? bus.s1_ready : bus.s0_ready, 0);
    nc();
    set_req(n, 1'b0, a, d, l, sz);
    #1;
    chk("issue_valid", bus.m_valid, 1);
    chk("issue_id", bus.m_id, n);
    chk("issue_addr", bus.m_addr, a);
    chk("issue_data", bus.m_data, d);
    chk("issue_len", bus.m_len, l);
    chk("issue_size", bus.m_size, sz);
    chk("issue_busy", bus.busy, 1);
    nc();
    chk("wait_valid", bus.m_valid, 0);
    chk("wait_addr_held", bus.m_addr, a);
    repeat (done_cyc - 2) nc();
    bus.m_done = 1'b1;
    bus.m_resp = rsp;
    #1;
    chk("done_early", (n == 0) ? bus.s0_done : bus.s1_done, 0);
    nc();
    bus.m_done = 1'b0;
    #1;
    own_done = (n == 0) ? bus.s0_done : bus.s1_done;
    oth_done = (n == 0) ? bus.s1_done : bus.s0_done;
    chk("done_own", own_done, 1);
    chk("done_oth", oth_done, 0);
    chk("done_resp", (n == 0) ? bus.s0_resp : bus.s1_resp, rsp);
    chk("done_busy", bus.busy, 0);
    nc();
    chk("done_pulse", (n == 0) ? bus.s0_done : bus.s1_done, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus.m_ready = 1'b1;
    bus.m_done  = 1'b0;
    bus.m_resp  = 2'b00;
    set_req(0, 1'b0, 32'h0, 64'h0, 8'h0, 2'b00);
    set_req(1, 1'b0, 32'h0, 64'h0, 8'h0, 2'b00);
    repeat (3) nc();
    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_spurious, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mfields", {bus.m_id, bus.m_addr, bus.m_len, bus.m_size}, 0);
    chk("rst_mdata", bus.m_data, 0);
    chk("rst_sout", {bus.s0_ready, bus.s1_ready, bus.s0_done, bus.s1_done,
                     bus.s0_resp, bus.s1_resp}, 0);
    reset_n = 1'b1;

    // single s0 transaction, done at cycle 5
    run_one(0, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h00, 2'b11, 2'b00, 5);
    chk("s1_quiet", bus.s1_done, 0);

    // tie after reset: s0, then s1 back-to-back, then s0 again
    do_reset();
    set_req(0, 1'b1, 32'hA000_0000, 64'hAAAA, 8'h03, 2'b11);
    set_req(1, 1'b1, 32'hB000_0004, 64'hBBBB, 8'h00, 2'b10);
    #1;
    chk("tie1_s0_ready", bus.s0_ready, 1);
    chk("tie1_s1_ready", bus.s1_ready, 0);
    nc();
    bus.s0_valid = 1'b0;
    #1;
    chk("tie1_id", bus.m_id, 0);
    chk("tie1_addr", bus.m_addr, 32'hA000_0000);
    chk("tie1_len", bus.m_len, 8'h03);
    chk("tie1_s1_wait", bus.s1_ready, 0);
    nc();
    chk("tie1_s1_wait2", bus.s1_ready, 0);
    nc();
    bus.m_done = 1'b1;
    bus.m_resp = 2'b01;
    nc();
    bus.m_done = 1'b0;
    #1;
    chk("tie1_s0_done", bus.s0_done, 1);
    chk("tie1_s0_resp", bus.s0_resp, 2'b01);
    chk("b2b_s1_ready", bus.s1_ready, 1);
    nc();
    bus.s1_valid = 1'b0;
    #1;
    chk("tie2_valid", bus.m_valid, 1);
    chk("tie2_id", bus.m_id, 1);
    chk("tie2_addr", bus.m_addr, 32'hB000_0004);
    chk("tie2_size", bus.m_size, 2'b10);
    nc();
    bus.m_done = 1'b1;
    bus.m_resp = 2'b10;
    nc();
    bus.m_done = 1'b0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    #1;
    chk("route_s1_done", bus.s1_done, 1);
    chk("route_s1_resp", bus.s1_resp, 2'b10);
    chk("route_s0_done", bus.s0_done, 0);
    chk("route_s0_resp", bus.s0_resp, 2'b01);
    chk("tie3_s0_ready", bus.s0_ready, 1);
    chk("tie3_s1_ready", bus.s1_ready, 0);
    nc();
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    #1;
    chk("tie3_id", bus.m_id, 0);
    nc();
    bus.m_done = 1'b1;
    bus.m_resp = 2'b00;
    nc();
    bus.m_done = 1'b0;
    #1;
    chk("tie3_s0_done", bus.s0_done, 1);
    chk("tie3_s1_resp_kept", bus.s1_resp, 2'b10);

    // backpressure: m_ready low for 4 ISSUE cycles
    nc();
    bus.m_ready = 1'b0;
    set_req(1, 1'b1, 32'hC000_0008, 64'hCAFE_F00D, 8'h07, 2'b01);
    #1;
    chk("bp_ready", bus.s1_ready, 1);
    nc();
    bus.s1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold_valid", bus.m_valid, 1);
      chk("bp_hold_addr", bus.m_addr, 32'hC000_0008);
      chk("bp_hold_data", bus.m_data, 64'hCAFE_F00D);
      nc();
    end
    bus.m_ready = 1'b1;
    #1;
    chk("bp_last_valid", bus.m_valid, 1);
    nc();
    chk("bp_wait_valid", bus.m_valid, 0);
    chk("bp_wait_len", bus.m_len, 8'h07);
    bus.m_done = 1'b1;
    bus.m_resp = 2'b11;
    nc();
    bus.m_done = 1'b0;
    #1;
    chk("bp_s1_done", bus.s1_done, 1);
    chk("bp_s1_resp", bus.s1_resp, 2'b11);

    // spurious m_done in IDLE
    nc();
    bus.m_done = 1'b1;
    nc();
    bus.m_done = 1'b0;
    #1;
    chk("spur_err", bus.err_spurious, 1);
    chk("spur_no_done", {bus.s0_done, bus.s1_done}, 0);
    chk("spur_busy", bus.busy, 0);
    run_one(0, 32'h0000_1000, 64'hDEAD_BEEF_0000_0001, 8'h01, 2'b10, 2'b00, 3);
    chk("spur_sticky", bus.err_spurious, 1);

    // reset in WAIT, then a fresh s1 request
    nc();
    set_req(0, 1'b1, 32'h1234_5678, 64'h55, 8'h00, 2'b00);
    nc();
    bus.s0_valid = 1'b0;
    nc();
    #1;
    chk("prerst_wait_busy", bus.busy, 1);
    reset_n = 1'b0;
    nc();
    reset_n = 1'b1;
    #1;
    chk("wrst_busy", bus.busy, 0);
    chk("wrst_err", bus.err_spurious, 0);
    chk("wrst_m", {bus.m_valid, bus.m_id, bus.m_addr}, 0);
    chk("wrst_s", {bus.s0_done, bus.s1_done, bus.s0_resp, bus.s1_resp}, 0);
    run_one(1, 32'h4000_0020, 64'h0102_0304_0506_0708, 8'h00, 2'b11, 2'b01, 4);
    chk("wrst_s0_quiet", bus.s0_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_w_arbiter.md
Name: axi_w_arbiter

Overview:
Two-requester arbiter in front of the AXI write master. Requester 0 is the dcache writeback port and requester 1 is the uncached/MMIO store port. Grants one write transaction at a time with round-robin fairness, and latches the winner's command so it is stable for the whole AW/W/B sequence. Routes the B-channel completion and response back to the owning requester.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, write data width
LEN_W, 8, burst length field width (beats-1)
ID_W, 4, AXI ID width; granted requester index placed in ID[0], upper bits 0
RESP_W, 2, AXI response width

Ports:
clk  in  1  clock
reset_n  in  1  reset
s0_valid  in  1  requester 0 write request
s0_ready  out  1  requester 0 accepted (1-cycle)
s0_addr  in  ADDR_W  requester 0 address
s0_data  in  DATA_W  requester 0 data
s0_len  in  LEN_W  requester 0 burst len
s0_size  in  2  requester 0 size (00=1B..11=8B)
s0_done  out  1  requester 0 write complete (1-cycle)
s0_resp  out  RESP_W  requester 0 response, valid with s0_done
s1_valid, s1_ready, s1_addr, s1_data, s1_len, s1_size, s1_done, s1_resp  same as s0_* for requester 1
m_valid  out  1  command valid to write master
m_ready  in  1  write master idle/accepting
m_id  out  ID_W  command ID
m_addr  out  ADDR_W  command address
m_data  out  DATA_W  command data
m_len  out  LEN_W  command len
m_size  out  2  command size
m_done  in  1  write master B handshake pulse
m_resp  in  RESP_W  B response, valid with m_done
busy  out  1  arbiter not IDLE
err_spurious  out  1  sticky: m_done seen outside WAIT

Behaviour:
- Reset: the interface is clk with reset_n, synchronous, active-low. State=IDLE; last_grant=1, so requester 0 wins the first tie. All outputs are 0: s*_ready, s*_done, s*_resp, m_valid, m_id, m_addr, m_data, m_len, m_size, busy, err_spurious. Latched command registers are cleared.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, request selection:
  - If only one s*_valid is high, select that requester.
  - If both are high, select the requester != last_grant.
  - sN_ready is driven combinationally high in the same IDLE cycle for the selected requester only.
  - On that edge: latch sN_addr/data/len/size into the command registers, set grant=N, set m_id = N zero-extended, go to ISSUE.
  - A requester must hold valid and fields stable until ready.
- ISSUE:
  - m_valid=1, and m_* reflect the latched registers.
  - On m_valid && m_ready: go to WAIT; m_valid drops the next cycle.
- WAIT:
  - m_valid=0; m_* stay held, because the master samples data during its W phase.
  - On m_done: pulse s{grant}_done for 1 cycle (registered, cycle after m_done), set s{grant}_resp=m_resp (held until the next done for that requester), set last_grant=grant, go to IDLE.
- Latency:
  - Accept at cycle 0, m_valid at cycle 1.
  - With m_ready high, WAIT at cycle 2.
  - sN_done appears 1 cycle after m_done.
  - Back-to-back: the arbiter re-enters IDLE in the same cycle sN_done is high, and can accept again that cycle.
- No s*_ready in ISSUE or WAIT. New requests wait regardless of priority; no preemption.
- Only the granted requester's done/resp change.
- m_done in IDLE or ISSUE is ignored for routing and sets err_spurious (sticky until reset).
- m_done in the same cycle as ISSUE handshake is impossible by protocol and is treated as spurious.
- A requester dropping valid after ready has no effect.
- last_grant updates only on completion, not on accept.
- busy = (state != IDLE).
- Reset mid-transaction aborts to IDLE. No done is issued, and the in-flight grant is lost.
- m_len, m_size and m_data are pass-through latched values; no arithmetic on them.

Test Plan:
- Single s0: s0_valid with addr=0x8000_0010, data=0x1122334455667788, len=0, size=11; m_ready=1; m_done+m_resp=00 at cycle 5 -> s0_ready at cycle 0, m_valid at cycle 1 only, m_addr/m_data match, m_id=0, s0_done at cycle 6 with s0_resp=00, s1_done stays 0.
- Tie after reset: s0 and s1 valid together -> s0 granted first; after its done, s1 is granted with m_id=1; after that, another tie grants s0 (alternation).
- Backpressure: m_ready=0 for 4 cycles in ISSUE -> m_valid held 5 cycles, m_* stable, no state change until m_ready=1.
- Response routing: grant s1, m_resp=10 -> s1_resp=10 with s1_done; s0_resp unchanged from its previous value.
- Spurious done: m_done pulse in IDLE -> err_spurious=1 and stays 1; no s*_done; the next transaction still completes normally.
- Reset in WAIT: reset_n low 1 cycle -> state IDLE, busy=0, all outputs 0, next s1 request granted normally.
